// File: rtl/qspi_framebuffer_responder.sv
// rtl/qspi_framebuffer_responder.sv - framebuffer control-bus responder with linear 4-bit pixel store
// Decodes {read, reset_read_ptr, write toggle, reset_write_ptr, wdata} and serves pixels 1 cycle later.
module qspi_framebuffer_responder #(
  parameter int         DEPTH      = 153600,
  parameter logic [3:0] INIT_VALUE = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ctrl_data_in,
  output logic [3:0] data_out,
  output logic       write_ack,
  output logic       frame_wrap,
  output logic       overrun
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [3:0]        mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_wtoggle;
  logic              rd_en;
  logic              wr_en;
  logic              rd_at_last;
  logic              wr_at_last;

  // reset_read_ptr suppresses the read; reset_write_ptr only redirects a write to address 0
  assign rd_en      = ctrl_data_in[7] & ~ctrl_data_in[6];
  assign wr_en      = ctrl_data_in[5] ^ last_wtoggle;
  assign wr_addr    = ctrl_data_in[4] ? '0 : wr_ptr;
  assign rd_at_last = (rd_ptr == LAST_ADDR);
  assign wr_at_last = (wr_addr == LAST_ADDR);

  // Pixel storage has no reset; the valid bits decide whether it is visible
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= ctrl_data_in[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      data_out   <= 4'h0;
      frame_wrap <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      if (ctrl_data_in[6]) begin
        rd_ptr <= '0;
      end else if (rd_en) begin
        data_out   <= valid[rd_ptr] ? mem[rd_ptr] : INIT_VALUE;
        frame_wrap <= rd_at_last;
        rd_ptr     <= rd_at_last ? '0 : rd_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      valid        <= '0;
      last_wtoggle <= 1'b0;
      write_ack    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (wr_en) begin
        valid[wr_addr] <= 1'b1;
        wr_ptr         <= wr_at_last ? '0 : wr_addr + ADDR_W'(1);
        last_wtoggle   <= ctrl_data_in[5];
        write_ack      <= ctrl_data_in[5];
        if (wr_at_last) begin
          overrun <= 1'b1;
        end
      end else if (ctrl_data_in[4]) begin
        wr_ptr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_framebuffer_responder.sv
// tb/tb_qspi_framebuffer_responder.sv - self-checking bench for qspi_framebuffer_responder (DEPTH=16)
module tb_qspi_framebuffer_responder;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] ctrl_data_in;
  logic [3:0] data_out;
  logic       write_ack;
  logic       frame_wrap;
  logic       overrun;

  qspi_framebuffer_responder #(.DEPTH(DEPTH), .INIT_VALUE(4'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_data_in (ctrl_data_in),
    .data_out     (data_out),
    .write_ack    (write_ack),
    .frame_wrap   (frame_wrap),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel array plus pointer integers, advanced once per clock edge
  int m_mem [DEPTH];
  bit m_valid [DEPTH];
  int m_rd = 0;
  int m_wr = 0;
  bit m_last = 0;
  int e_do = 0;
  int e_ack = 0;
  int e_wrap = 0;
  int e_ov = 0;

  always @(posedge clk) begin
    logic [7:0] c;
    int a;
    c = ctrl_data_in;
    if (!rst_n) begin
      m_rd = 0; m_wr = 0; m_last = 0;
      e_do = 0; e_ack = 0; e_wrap = 0; e_ov = 0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    end else begin
      e_wrap = 0;
      if (c[6]) begin
        m_rd = 0;
      end else if (c[7]) begin
        e_do   = m_valid[m_rd] ? m_mem[m_rd] : 0;
        e_wrap = (m_rd == DEPTH - 1);
        m_rd   = (m_rd + 1) % DEPTH;
      end
      if (c[5] != m_last) begin
        a = c[4] ? 0 : m_wr;
        if (a == DEPTH - 1) e_ov = 1;
        m_mem[a]   = c[3:0];
        m_valid[a] = 1;
        m_wr       = (a + 1) % DEPTH;
        m_last     = c[5];
        e_ack      = c[5];
      end else if (c[4]) begin
        m_wr = 0;
      end
      #1;
      if (rst_n) begin
        check("model data_out", data_out, e_do);
        check("model write_ack", write_ack, e_ack);
        check("model frame_wrap", frame_wrap, e_wrap);
        check("model overrun", overrun, e_ov);
      end
    end
  end

  logic tog = 1'b0;

  function automatic logic [7:0] mk(input logic rd, input logic rrst, input logic t,
                                    input logic wrst, input logic [3:0] wd);
    return {rd, rrst, t, wrst, wd};
  endfunction

  task automatic cyc(input logic [7:0] c);
    ctrl_data_in = c;
    @(negedge clk);
  endtask

  task automatic wr_px(input logic [3:0] wd);
    tog = ~tog;
    cyc(mk(1'b0, 1'b0, tog, 1'b0, wd));
  endtask

  task automatic rd_px();
    cyc(mk(1'b1, 1'b0, tog, 1'b0, 4'h0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ctrl_data_in = 8'h00;
    tog = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int wraps;

  initial begin
    rst_n = 1'b0;
    ctrl_data_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset data_out", data_out, 0);
    check("reset write_ack", write_ack, 0);
    check("reset frame_wrap", frame_wrap, 0);
    check("reset overrun", overrun, 0);

    // 1: fill all 16 entries, then read them back across the wrap
    cyc(mk(1'b0, 1'b0, tog, 1'b1, 4'h0));
    for (int i = 0; i < DEPTH; i++) begin
      wr_px(4'((i + 1) % DEPTH));
      check("t1 write_ack", write_ack, int'(tog));
      if (i == DEPTH - 2) check("t1 overrun before last", overrun, 0);
    end
    check("t1 overrun after 16", overrun, 1);
    cyc(mk(1'b0, 1'b1, tog, 1'b0, 4'h0));
    wraps = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_px();
      check("t1 read data", data_out, (i + 1) % DEPTH);
      if (frame_wrap) wraps++;
    end
    cyc(mk(1'b0, 1'b0, tog, 1'b0, 4'h0));
    check("t1 wrap idle", frame_wrap, 0);
    check("t1 wrap count", wraps, 1);

    // 2: unwritten entries read as INIT_VALUE; a held toggle level writes once
    do_reset();
    rd_px();
    check("t2 init addr0", data_out, 0);
    rd_px();
    check("t2 init addr1", data_out, 0);
    tog = 1'b1;
    for (int i = 0; i < 10; i++) cyc(mk(1'b0, 1'b0, tog, 1'b0, 4'h9));
    cyc(mk(1'b0, 1'b1, tog, 1'b0, 4'h0));
    rd_px();
    check("t2 held write addr0", data_out, 9);
    rd_px();
    check("t2 no second write", data_out, 0);

    // 3: same-cycle read and write of address 3 returns old content
    cyc(mk(1'b0, 1'b1, tog, 1'b1, 4'h0));
    wr_px(4'h9); wr_px(4'h1); wr_px(4'h2); wr_px(4'h5);
    cyc(mk(1'b0, 1'b0, tog, 1'b1, 4'h0));
    wr_px(4'h9); wr_px(4'h1); wr_px(4'h2);
    cyc(mk(1'b0, 1'b1, tog, 1'b0, 4'h0));
    rd_px(); rd_px(); rd_px();
    tog = ~tog;
    cyc(mk(1'b1, 1'b0, tog, 1'b0, 4'hA));
    check("t3 read-before-write", data_out, 5);
    cyc(mk(1'b0, 1'b1, tog, 1'b0, 4'h0));
    for (int i = 0; i < 4; i++) rd_px();
    check("t3 reread addr3", data_out, 4'hA);

    // 4: write toggle with reset_write_ptr lands at 0; reset_read_ptr blocks a read
    tog = ~tog;
    cyc(mk(1'b0, 1'b0, tog, 1'b1, 4'h7));
    wr_px(4'h3);
    cyc(mk(1'b1, 1'b1, tog, 1'b0, 4'h0));
    check("t4 rrst holds data_out", data_out, 4'hA);
    rd_px();
    check("t4 addr0", data_out, 7);
    rd_px();
    check("t4 addr1", data_out, 3);

    // 5: VGA-style read every second cycle
    cyc(mk(1'b0, 1'b0, tog, 1'b1, 4'h0));
    for (int i = 0; i < 8; i++) wr_px(4'(i + 1));
    cyc(mk(1'b0, 1'b1, tog, 1'b0, 4'h0));
    for (int i = 0; i < 8; i++) begin
      rd_px();
      check("t5 step", data_out, i + 1);
      cyc(mk(1'b0, 1'b0, tog, 1'b0, 4'h0));
      check("t5 hold", data_out, i + 1);
    end

    // 6: asynchronous reset mid-stream, toggle high at release
    do_reset();
    for (int i = 0; i < 5; i++) wr_px(4'(i + 1));
    rd_px(); rd_px(); rd_px();
    check("t6 pre data_out", data_out, 3);
    check("t6 pre write_ack", write_ack, 1);
    #2;
    rst_n = 1'b0;
    ctrl_data_in = 8'h26;
    #1;
    check("t6 async data_out", data_out, 0);
    check("t6 async write_ack", write_ack, 0);
    check("t6 async frame_wrap", frame_wrap, 0);
    check("t6 async overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tog = 1'b1;
    @(negedge clk);
    check("t6 release write_ack", write_ack, 1);
    cyc(8'h26);
    rd_px();
    check("t6 addr0 after release", data_out, 6);
    rd_px();
    check("t6 addr1 cleared", data_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
